// File: rtl/sram_array_requester_pkg.sv
// Shared types and defaults for the cache-array requester.
// Address/data widths match the BRAM macro wrappers.
package sram_array_pkg;

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  localparam int unsigned DEF_ADDR_W = 9;
  localparam int unsigned DEF_DATA_W = 73;
  localparam int unsigned DEF_DEPTH  = 512;
  localparam logic [DEF_DATA_W-1:0] DEF_INIT_VALUE = '0;

endpackage

// File: rtl/sram_array_requester_resp_hold.sv
// One-entry skid buffer behind the array's 1-cycle read port.
// Read data bypasses straight through unless the consumer stalls.
module sram_resp_hold
  import sram_array_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_rd_pending,
  input  logic [DATA_W-1:0] i_rdata,
  input  logic              i_resp_ready,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_hold_valid
);

  logic              r_hold_valid;
  logic [DATA_W-1:0] r_hold_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_data  <= '0;
    end else if (i_rd_pending && !i_resp_ready) begin
      r_hold_valid <= 1'b1;
      r_hold_data  <= i_rdata;
    end else if (r_hold_valid && i_resp_ready) begin
      r_hold_valid <= 1'b0;
    end
  end

  assign o_resp_valid = i_rd_pending | r_hold_valid;
  assign o_resp_rdata = r_hold_valid ? r_hold_data : i_rdata;
  assign o_hold_valid = r_hold_valid;

endmodule

// File: rtl/sram_array_requester.sv
// Cache-array requester: clears the array after reset, then turns
// a valid/ready request channel into RW0_* strobes.
module sram_array_requester
  import sram_array_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter logic [DATA_W-1:0] INIT_VALUE = DEF_INIT_VALUE
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              RW0_clk,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_init_done;
  logic              r_rd_pending;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              w_accept;
  logic              w_hold_valid;
  logic              w_sweep_end;

  assign RW0_clk     = clock;
  assign init_done   = r_init_done;
  assign w_accept    = req_valid && req_ready;
  assign w_sweep_end = (r_state == ST_INIT) && (r_init_cnt == LAST);

  assign req_ready = r_init_done && !w_hold_valid
                   && !(r_rd_pending && !resp_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_init_done  <= 1'b0;
      r_rd_pending <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rd_pending <= w_accept && !req_wen;
      r_addr       <= RW0_addr;
      r_wdata      <= RW0_wdata;
      if (r_state == ST_INIT) r_init_cnt <= r_init_cnt + ADDR_W'(1);
      if (w_sweep_end) r_init_done <= 1'b1;
    end
  end

  // Strobes are gated by reset_n so nothing reaches the macro while held.
  always_comb begin
    w_state_nxt = r_state;
    RW0_en      = 1'b0;
    RW0_wmode   = 1'b0;
    RW0_addr    = r_addr;
    RW0_wdata   = r_wdata;
    unique case (r_state)
      ST_INIT: begin
        RW0_en    = reset_n;
        RW0_wmode = reset_n;
        RW0_addr  = r_init_cnt;
        RW0_wdata = INIT_VALUE;
        if (w_sweep_end) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_accept) begin
          RW0_en    = 1'b1;
          RW0_wmode = req_wen;
          RW0_addr  = req_addr;
          if (req_wen) RW0_wdata = req_wdata;
        end
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  sram_resp_hold #(
    .DATA_W (DATA_W)
  ) u_hold (
    .clk          (clock),
    .rst_n        (reset_n),
    .i_rd_pending (r_rd_pending),
    .i_rdata      (RW0_rdata),
    .i_resp_ready (resp_ready),
    .o_resp_valid (resp_valid),
    .o_resp_rdata (resp_rdata),
    .o_hold_valid (w_hold_valid)
  );

endmodule

// File: tb/tb_sram_array_requester.sv
// Directed bench for sram_array_requester with a behavioural array.
// Vector table plus hand sequences for backpressure and reset.
module tb_sram_array_requester;

  localparam int AW = 9;
  localparam int DW = 73;
  localparam int DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid, req_ready, req_wen;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          RW0_clk, RW0_en, RW0_wmode;
  logic [AW-1:0] RW0_addr;
  logic [DW-1:0] RW0_wdata, RW0_rdata;

  int total = 0;
  int bad = 0;

  logic [DW-1:0] mem [DEPTH];

  always #5 clock = ~clock;

  sram_array_requester dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_wen    (req_wen),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .RW0_clk    (RW0_clk),
    .RW0_en     (RW0_en),
    .RW0_wmode  (RW0_wmode),
    .RW0_addr   (RW0_addr),
    .RW0_wdata  (RW0_wdata),
    .RW0_rdata  (RW0_rdata)
  );

  // Behavioural single-port array, 1-cycle read latency.
  always @(posedge RW0_clk) begin
    if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= RW0_wdata;
      else RW0_rdata <= mem[RW0_addr];
    end
  end

  typedef struct {
    logic          wen;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  localparam logic [DW-1:0] D5 = 73'h1_2345_6789_ABCD_EF01;

  task automatic check(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input int i);
    logic [DW-1:0] v;
    v = 73'h1_0000_0000_0000_0000 | DW'(32'h0101_0101 * (i + 1));
    return v;
  endfunction

  task automatic idle();
    req_valid = 1'b0;
    req_wen   = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  // Release reset and watch the full clear sweep.
  task automatic release_and_sweep();
    int errs;
    errs = 0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      if (!(RW0_en && RW0_wmode && RW0_addr == AW'(i) &&
            RW0_wdata == '0 && !req_ready && !init_done &&
            !resp_valid))
        errs++;
    end
    check("sweep_bad_cycles", DW'(errs), '0);
    @(negedge clock);
    check("init_done_after_sweep", DW'(init_done), 1);
    check("req_ready_after_sweep", DW'(req_ready), 1);
    check("en_idle_after_sweep", DW'(RW0_en), 0);
  endtask

  task automatic apply(input vec_t v, input string nm);
    @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_wen   = v.wen;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    @(negedge clock);
    check({nm, "_ready"}, DW'(req_ready), 1);
    check({nm, "_strobe"}, DW'({RW0_en, RW0_wmode, RW0_addr}),
          DW'({1'b1, v.wen, v.addr}));
    @(posedge clock);
    #1 idle();
    @(negedge clock);
    check({nm, "_rvalid"}, DW'(resp_valid), DW'(!v.wen));
    if (!v.wen) check({nm, "_rdata"}, resp_rdata, v.exp);
  endtask

  vec_t tbl [6];

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = 73'h0_DEAD_BEEF_0000_0000 | DW'(i);
    RW0_rdata  = '0;
    reset_n    = 1'b0;
    resp_ready = 1'b1;
    idle();
    tbl[0] = '{1'b1, 9'h005, D5, '0};
    tbl[1] = '{1'b0, 9'h005, '0, D5};
    tbl[2] = '{1'b0, 9'h1FF, '0, '0};
    tbl[3] = '{1'b1, 9'h0A0, 73'h0_FFFF_0000_FFFF_0000, '0};
    tbl[4] = '{1'b0, 9'h0A0, '0, 73'h0_FFFF_0000_FFFF_0000};
    tbl[5] = '{1'b0, 9'h000, '0, '0};

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_init_done", DW'(init_done), 0);
    check("rst_req_ready", DW'(req_ready), 0);
    check("rst_en", DW'({RW0_en, RW0_wmode, resp_valid}), 0);
    release_and_sweep();

    for (int i = 0; i < 6; i++) apply(tbl[i], $sformatf("vec%0d", i));

    // Write then read the same address on the very next cycle.
    @(posedge clock);
    #1;
    req_valid = 1'b1; req_wen = 1'b1;
    req_addr = 9'h020; req_wdata = 73'h1_5555_AAAA_5555_AAAA;
    @(posedge clock);
    #1 req_wen = 1'b0;
    @(posedge clock);
    #1 idle();
    @(negedge clock);
    check("wr_rd_bypass_valid", DW'(resp_valid), 1);
    check("wr_rd_bypass_data", resp_rdata, 73'h1_5555_AAAA_5555_AAAA);

    for (int i = 0; i < 8; i++) apply('{1'b1, AW'(9'h010 + i), pat(i), '0},
                                      $sformatf("fill%0d", i));

    // Back-to-back reads, one response per cycle.
    for (int i = 0; i <= 8; i++) begin
      @(posedge clock);
      #1;
      if (i < 8) begin
        req_valid = 1'b1; req_wen = 1'b0; req_addr = AW'(9'h010 + i);
      end else idle();
      @(negedge clock);
      if (i < 8) check($sformatf("b2b_ready%0d", i), DW'(req_ready), 1);
      if (i > 0) begin
        check($sformatf("b2b_valid%0d", i - 1), DW'(resp_valid), 1);
        check($sformatf("b2b_data%0d", i - 1), resp_rdata, pat(i - 1));
      end
    end

    // Backpressure: read 0x05, stall 3 cycles, attempt a write meanwhile.
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 9'h005;
    @(posedge clock);
    #1;
    req_wen = 1'b1; req_wdata = 73'h0_BAD0_BAD0_BAD0_BAD0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check($sformatf("bp_valid%0d", c), DW'(resp_valid), 1);
      check($sformatf("bp_data%0d", c), resp_rdata, D5);
      check($sformatf("bp_ready%0d", c), DW'(req_ready), 0);
      check($sformatf("bp_en%0d", c), DW'(RW0_en), 0);
      @(posedge clock);
      #1;
    end
    resp_ready = 1'b1;
    idle();
    @(negedge clock);
    check("bp_release_valid", DW'(resp_valid), 1);
    check("bp_release_data", resp_rdata, D5);
    @(negedge clock);
    check("bp_once", DW'(resp_valid), 0);
    check("bp_ready_back", DW'(req_ready), 1);
    apply('{1'b0, 9'h005, '0, D5}, "bp_write_blocked");

    // Reset pulse in the middle of the sweep at address 200.
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock);
    #1 reset_n = 1'b1;
    begin
      int n;
      n = 0;
      do begin
        @(negedge clock);
        n++;
      end while (RW0_addr != 9'd200 && n < 600);
      check("reach_addr200", DW'(n < 600), 1);
    end
    reset_n = 1'b0;
    #1;
    check("mid_rst_init_done", DW'(init_done), 0);
    check("mid_rst_strobes", DW'({RW0_en, RW0_wmode, req_ready, resp_valid}), 0);
    release_and_sweep();

    // Reset pulse while a stalled response sits in the hold buffer.
    @(posedge clock);
    #1;
    resp_ready = 1'b0;
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 9'h005;
    @(posedge clock);
    #1 idle();
    @(negedge clock);
    @(negedge clock);
    check("hold_before_rst", DW'(resp_valid), 1);
    reset_n = 1'b0;
    #1;
    check("hold_rst_valid", DW'(resp_valid), 0);
    resp_ready = 1'b1;
    release_and_sweep();
    begin
      int stale;
      stale = 0;
      repeat (4) begin
        @(negedge clock);
        if (resp_valid) stale++;
      end
      check("no_stale_resp", DW'(stale), 0);
    end
    apply('{1'b0, 9'h005, '0, '0}, "cleared_after_reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_array_requester.md
Name: sram_array_requester

Overview:
- Initiator-side controller for the single-port cache-array BRAM macros (`RW0_*` interface: address, enable, write-mode, write data, read data).
- Clears every entry after reset.
- Converts a valid/ready request channel into `RW0_*` strobes.
- Returns read data on a valid/ready response channel. Absorbs the macro's 1-cycle read latency with a 1-entry hold buffer so that backpressure never loses data.
- Sits between cache pipeline logic and one array instance.

Parameters:
- ADDR_W, 9, array address width
- DATA_W, 73, array word width
- DEPTH, 512, number of entries; DEPTH <= 2**ADDR_W
- INIT_VALUE, 0, DATA_W-bit value written to every entry during init

Ports:
- clock  input  1  sole clock; also drives the array clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  request accepted when req_valid && req_ready
- req_wen  input  1  1 = write, 0 = read
- req_addr  input  ADDR_W  request address
- req_wdata  input  DATA_W  write data
- resp_valid  output  1  read data available
- resp_ready  input  1  consumer takes data
- resp_rdata  output  DATA_W  read data
- init_done  output  1  high once the clear sweep has completed
- RW0_clk  output  1  equals clock
- RW0_en  output  1  array enable
- RW0_wmode  output  1  array write enable
- RW0_addr  output  ADDR_W  array address
- RW0_wdata  output  DATA_W  array write data
- RW0_rdata  input  DATA_W  array read data, valid 1 cycle after a read enable

Behaviour:
- Reset values (async, while reset_n=0): state=INIT, init_cnt=0, init_done=0, req_ready=0, resp_valid=0, rd_pending=0, hold_valid=0, RW0_en=0, RW0_wmode=0.
- States: INIT, RUN.
- INIT:
  - Each cycle drives RW0_en=1, RW0_wmode=1, RW0_addr=init_cnt, RW0_wdata=INIT_VALUE.
  - init_cnt increments.
  - When init_cnt==DEPTH-1 is written: next state RUN, init_done=1.
  - The sweep takes exactly DEPTH cycles after reset release.
  - req_ready=0 throughout.
- RUN: init_done stays 1 until reset.
- req_ready = init_done && !hold_valid && !(rd_pending && !resp_ready). This is combinational on resp_ready, by design.
- Accepted write: same cycle, RW0_en=1, RW0_wmode=1, RW0_addr=req_addr, RW0_wdata=req_wdata. No response is produced.
- Accepted read: same cycle, RW0_en=1, RW0_wmode=0, RW0_addr=req_addr; rd_pending is set for the next cycle.
- No accept: RW0_en=0, RW0_wmode=0. RW0_addr and RW0_wdata are don't-care but are held stable.
- Response path:
  - rd_pending cycle: resp_valid=1, resp_rdata=RW0_rdata (bypass). If resp_ready=0, RW0_rdata is captured into the hold register and hold_valid is set.
  - hold_valid cycle: resp_valid=1, resp_rdata=hold register. hold_valid clears on resp_ready.
  - rd_pending and hold_valid are never both 1; req_ready guarantees this.
- Throughput: reads issue back-to-back, 1 per cycle, while resp_ready=1. Read latency is 1 cycle from accept to resp_valid.
- Ordering: the single port serialises accesses. A read accepted the cycle after a write to the same address returns the new data.
- Reset mid-sweep or mid-response: all state is dropped. Any in-flight or held response is lost, with no resp_valid after reset. The sweep restarts from address 0.
- init_cnt width: ADDR_W bits. Terminal compare is against DEPTH-1, so there is no wrap-around.

Decomposition:
- Package sram_array_pkg:
  - state enum (INIT, RUN)
  - default ADDR_W, DATA_W, DEPTH constants
  - INIT_VALUE default
- Sub-module sram_resp_hold: 1-entry hold/skid buffer taking rd_pending, RW0_rdata and resp_ready, producing resp_valid, resp_rdata and hold_valid.
- Init sweep, request issue and req_ready generation stay in the top module.

Test Plan:
- Reset release, DEPTH=512 -> RW0_en=RW0_wmode=1 for addresses 0..511 over 512 consecutive cycles; init_done rises on the cycle after address 511 is written; req_ready=0 until then.
- After init: write addr 0x05 data 0x1_2345_6789_ABCD_EF01, then read 0x05 the next cycle -> resp_valid 1 cycle after the read accept, resp_rdata=0x1_2345_6789_ABCD_EF01. Read of untouched 0x1FF -> 0.
- Reads to 0x10..0x17 back-to-back with resp_ready=1 -> 8 responses on 8 consecutive cycles, in order; req_ready is never deasserted.
- Read 0x05 with resp_ready=0 for 3 cycles -> resp_valid held with a stable value; req_ready=0; a write to 0x05 is not accepted. After resp_ready=1, the same data is returned once and req_ready returns to 1.
- reset_n pulsed low at sweep address 200 -> outputs go to reset values immediately; the sweep restarts at 0 and init_done rises 512 cycles after release.
- reset_n pulsed low while hold_valid=1 -> resp_valid=0 immediately; no stale response after re-init.
